// File: rtl/data_router_pkg.sv
// Shared types and widths for the data_router sequencer.
// Imported by tile_step_cnt and data_router_ctrl.
package data_router_pkg;

    localparam int COL_W   = 28;
    localparam int ROW_W   = 8;
    localparam int BANK_W  = 8;
    localparam int RPSEL_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_PE,
        S_ADV,
        S_FIN
    } dr_ctrl_state_e;

endpackage

// File: rtl/data_router_ctrl_step.sv
// tile_step_cnt: accumulator stepping by STEP with an index that
// wraps both back to zero once it reaches limit-1.
module tile_step_cnt
    import data_router_pkg::*;
#(
    parameter int W    = 8,
    parameter int LW   = 8,
    parameter int STEP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    input  logic [LW-1:0] limit,
    output logic [W-1:0]  value,
    output logic [LW-1:0] index,
    output logic          last
);

    logic [W-1:0]  value_q, value_d;
    logic [LW-1:0] index_q, index_d;

    assign last  = (index_q == limit - LW'(1));
    assign value = value_q;
    assign index = index_q;

    // next value: clear wins, then step or wrap on the last index
    always_comb begin
        value_d = value_q;
        index_d = index_q;
        if (clr) begin
            value_d = '0;
            index_d = '0;
        end else if (inc) begin
            if (last) begin
                value_d = '0;
                index_d = '0;
            end else begin
                value_d = value_q + W'(STEP);
                index_d = index_q + LW'(1);
            end
        end
    end

    // counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            index_q <= '0;
        end else begin
            value_q <= value_d;
            index_q <= index_d;
        end
    end

endmodule

// File: rtl/data_router_ctrl.sv
// data_router_ctrl: walks a depthwise layer bank/row/col tile by tile.
// Optional DR_CTRL_PERF_EN adds stall_cyc / pe_cyc counters.
module data_router_ctrl
    import data_router_pkg::*;
#(
    parameter int POX    = 16,
    parameter int POY    = 3,
    parameter int STRIDE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cfg_dw,
    input  logic [15:0]        cfg_tx,
    input  logic [7:0]         cfg_ty,
    input  logic [7:0]         cfg_nch,
    input  logic               buf_rdy,
    input  logic               dwpe_ena,
    output logic               rd_req,
    output logic [BANK_W-1:0]  bank,
    output logic [ROW_W-1:0]   row,
    output logic [COL_W-1:0]   col,
    output logic [RPSEL_W-1:0] rpsel,
    output logic               blkend,
    output logic               dw_comp,
    output logic               busy,
    output logic               done
`ifdef DR_CTRL_PERF_EN
    ,
    output logic [31:0]        stall_cyc,
    output logic [31:0]        pe_cyc
`endif
);

    localparam int COL_STEP = POX * STRIDE;
    localparam int ROW_STEP = POY * STRIDE;
    localparam int BUFH     = STRIDE + 1;

    dr_ctrl_state_e     state_q, state_d;
    logic [15:0]        tx_q, tx_d;
    logic [7:0]         ty_q, ty_d;
    logic [7:0]         nch_q, nch_d;
    logic               dw_q, dw_d;
    logic               seen_q, seen_d;
    logic [RPSEL_W-1:0] rpsel_q, rpsel_d;

    logic        start_ok, adv;
    logic        col_last, row_last, bank_last;
    logic [15:0] col_idx;
    logic [7:0]  row_idx, bank_idx;

    assign start_ok = (state_q == S_IDLE) && start;
    assign adv      = (state_q == S_ADV);

    tile_step_cnt #(.W(COL_W), .LW(16), .STEP(COL_STEP)) u_col (
        .clk(clk), .rst_n(rst_n), .clr(start_ok), .inc(adv),
        .limit(tx_q), .value(col), .index(col_idx), .last(col_last)
    );

    tile_step_cnt #(.W(ROW_W), .LW(8), .STEP(ROW_STEP)) u_row (
        .clk(clk), .rst_n(rst_n), .clr(start_ok),
        .inc(adv && col_last),
        .limit(ty_q), .value(row), .index(row_idx), .last(row_last)
    );

    tile_step_cnt #(.W(BANK_W), .LW(8), .STEP(1)) u_bank (
        .clk(clk), .rst_n(rst_n), .clr(start_ok),
        .inc(adv && col_last && row_last),
        .limit(nch_q), .value(bank), .index(bank_idx), .last(bank_last)
    );

    // sequencer next state, cfg latch, PE falling-edge tracking
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        nch_d   = nch_q;
        dw_d    = dw_q;
        seen_d  = seen_q;
        rpsel_d = rpsel_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    tx_d    = cfg_tx;
                    ty_d    = cfg_ty;
                    nch_d   = cfg_nch;
                    dw_d    = cfg_dw;
                    rpsel_d = '0;
                    seen_d  = 1'b0;
                    if (cfg_tx == '0 || cfg_ty == '0 || cfg_nch == '0)
                        state_d = S_FIN;
                    else
                        state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (buf_rdy) state_d = S_WAIT_PE;
            end
            S_WAIT_PE: begin
                if (seen_q && !dwpe_ena) begin
                    seen_d  = 1'b0;
                    state_d = S_ADV;
                end else if (dwpe_ena) begin
                    seen_d = 1'b1;
                end
            end
            S_ADV: begin
                if (col_last) begin
                    if (row_last)
                        rpsel_d = '0;
                    else if (rpsel_q == RPSEL_W'(BUFH - 1))
                        rpsel_d = '0;
                    else
                        rpsel_d = rpsel_q + RPSEL_W'(1);
                end
                if (col_last && row_last && bank_last)
                    state_d = S_FIN;
                else
                    state_d = S_ISSUE;
            end
            S_FIN: begin
                dw_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // sequencer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tx_q    <= '0;
            ty_q    <= '0;
            nch_q   <= '0;
            dw_q    <= 1'b0;
            seen_q  <= 1'b0;
            rpsel_q <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            nch_q   <= nch_d;
            dw_q    <= dw_d;
            seen_q  <= seen_d;
            rpsel_q <= rpsel_d;
        end
    end

    assign rd_req  = (state_q == S_ISSUE);
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_FIN);
    assign blkend  = adv && col_last && row_last;
    assign dw_comp = dw_q;
    assign rpsel   = rpsel_q;

`ifdef DR_CTRL_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] pe_q, pe_d;

    // saturating stall / PE-busy cycle counters, cleared on start
    always_comb begin
        stall_d = stall_q;
        pe_d    = pe_q;
        if (start_ok) begin
            stall_d = '0;
            pe_d    = '0;
        end else begin
            if (state_q == S_ISSUE && !buf_rdy && stall_q != '1)
                stall_d = stall_q + 32'd1;
            if (state_q == S_WAIT_PE && pe_q != '1)
                pe_d = pe_q + 32'd1;
        end
    end

    // perf registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            pe_q    <= '0;
        end else begin
            stall_q <= stall_d;
            pe_q    <= pe_d;
        end
    end

    assign stall_cyc = stall_q;
    assign pe_cyc    = pe_q;
`endif

endmodule
